// File: rtl/munoc_resp_packet_pkg.sv
// munoc_resp_packet_pkg
// Shared definitions for the BNI response packet format: packet type codes,
// header field widths/offsets, packer FSM encoding and the RDATA byte-lane
// mapping used by both the packer and the master-side receiver.
package munoc_resp_packet_pkg;

   localparam logic PKT_TYPE_B = 1'b0;
   localparam logic PKT_TYPE_R = 1'b1;

   localparam int HDR_TYPE_W = 1;
   localparam int HDR_RESP_W = 2;
   localparam int HDR_LAST_W = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2
   } pkt_state_e;

   // Header layout, MSB first: type | dest | tid | resp | rlast | zero pad
   function automatic int hdr_width(input int node_w, input int tid_w);
      return HDR_TYPE_W + node_w + tid_w + HDR_RESP_W + HDR_LAST_W;
   endfunction

   function automatic int hdr_type_lsb(input int flit_w);
      return flit_w - HDR_TYPE_W;
   endfunction

   function automatic int hdr_dest_lsb(input int flit_w, input int node_w);
      return hdr_type_lsb(flit_w) - node_w;
   endfunction

   function automatic int hdr_tid_lsb(input int flit_w, input int node_w, input int tid_w);
      return hdr_dest_lsb(flit_w, node_w) - tid_w;
   endfunction

   function automatic int hdr_resp_lsb(input int flit_w, input int node_w, input int tid_w);
      return hdr_tid_lsb(flit_w, node_w, tid_w) - HDR_RESP_W;
   endfunction

   function automatic int hdr_last_lsb(input int flit_w, input int node_w, input int tid_w);
      return hdr_resp_lsb(flit_w, node_w, tid_w) - HDR_LAST_W;
   endfunction

   // Byte k of the AXI word lands in byte (nbytes-1-k) on the link; the
   // receiver applies the same mapping to restore the original order.
   function automatic int byte_lane_rev(input int k, input int nbytes);
      return nbytes - 1 - k;
   endfunction

endpackage

// File: rtl/munoc_resp_rr_arbiter.sv
// munoc_resp_rr_arbiter
// Two-input (B, R) round-robin grant. The pointer names the preferred
// channel when both request; it moves to the other channel on each update.
// lock_r_i forces the grant to R (B is held off) without moving the pointer.
module munoc_resp_rr_arbiter
   import munoc_resp_packet_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_b_i,
   input  logic req_r_i,
   input  logic lock_r_i,
   input  logic update_i,
   output logic gnt_b_o,
   output logic gnt_r_o
);

   logic ptr_q, ptr_d;

   // Grant selection
   always_comb begin
      gnt_b_o = 1'b0;
      gnt_r_o = 1'b0;
      if (lock_r_i) begin
         gnt_r_o = req_r_i;
      end else if (req_b_i && req_r_i) begin
         if (ptr_q == PKT_TYPE_B) gnt_b_o = 1'b1;
         else                     gnt_r_o = 1'b1;
      end else begin
         gnt_b_o = req_b_i;
         gnt_r_o = req_r_i;
      end
   end

   // Pointer moves to the channel that was not granted
   always_comb begin
      ptr_d = ptr_q;
      if (update_i) ptr_d = gnt_b_o ? PKT_TYPE_R : PKT_TYPE_B;
   end

   // Pointer register, resets to prefer B
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= PKT_TYPE_B;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/munoc_response_flit_packer.sv
// munoc_response_flit_packer
// Slave-side response packetizer: arbitrates AXI B/R responses and
// serializes each into a header flit plus (for R) byte-reversed body flits.
// Optional build macro: MUNOC_RESP_PACKER_BURST_LOCK_EN keeps arbitration on
// R from the first granted non-last beat of a burst until its rlast beat.
//
// state | meaning
// IDLE  | waiting for a response; grants and latches one
// HEAD  | header flit presented on the link
// BODY  | RDATA body flit [cnt] presented, most significant flit first
module munoc_response_flit_packer
   import munoc_resp_packet_pkg::*;
#(
   parameter int BW_FLIT    = 32,
   parameter int BW_RDATA   = 64,
   parameter int BW_TID     = 4,
   parameter int BW_NODE_ID = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  bvalid_i,
   output logic                  bready_o,
   input  logic [BW_TID-1:0]     bid_i,
   input  logic [1:0]            bresp_i,
   input  logic [BW_NODE_ID-1:0] bdest_i,
   input  logic                  rvalid_i,
   output logic                  rready_o,
   input  logic [BW_TID-1:0]     rid_i,
   input  logic [BW_RDATA-1:0]   rdata_i,
   input  logic [1:0]            rresp_i,
   input  logic                  rlast_i,
   input  logic [BW_NODE_ID-1:0] rdest_i,
   output logic                  flit_valid_o,
   input  logic                  flit_ready_i,
   output logic                  flit_head_o,
   output logic                  flit_tail_o,
   output logic [BW_FLIT-1:0]    flit_data_o
);

   localparam int NB       = BW_RDATA / BW_FLIT;
   localparam int NBYTES   = BW_RDATA / 8;
   localparam int CW       = (NB > 1) ? $clog2(NB) : 1;
   localparam int HW       = hdr_width(BW_NODE_ID, BW_TID);
   localparam int TYPE_LSB = hdr_type_lsb(BW_FLIT);
   localparam int DEST_LSB = hdr_dest_lsb(BW_FLIT, BW_NODE_ID);
   localparam int TID_LSB  = hdr_tid_lsb(BW_FLIT, BW_NODE_ID, BW_TID);
   localparam int RESP_LSB = hdr_resp_lsb(BW_FLIT, BW_NODE_ID, BW_TID);
   localparam int LAST_LSB = hdr_last_lsb(BW_FLIT, BW_NODE_ID, BW_TID);

   if (HW > BW_FLIT) begin : g_chk_hdr
      $error("header of %0d bits does not fit a %0d-bit flit", HW, BW_FLIT);
   end
   if ((BW_RDATA % BW_FLIT) != 0 || (BW_RDATA % 8) != 0 || NB < 1) begin : g_chk_data
      $error("BW_RDATA must be a nonzero multiple of BW_FLIT and of 8");
   end

   pkt_state_e            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  is_r_q, is_r_d;
   logic [BW_NODE_ID-1:0] dest_q, dest_d;
   logic [BW_TID-1:0]     tid_q, tid_d;
   logic [1:0]            resp_q, resp_d;
   logic                  last_q, last_d;
   logic [BW_RDATA-1:0]   rdata_q, rdata_d;

   logic                  req_b, req_r, gnt_b, gnt_r, accept, burst_lock;
   logic [BW_RDATA-1:0]   rdata_rev;
   logic [BW_FLIT-1:0]    hdr_flit, body_flit;

   // Requests only count in IDLE and outside reset, so handshakes stay low otherwise
   assign req_b  = bvalid_i && (state_q == ST_IDLE) && !rst_i;
   assign req_r  = rvalid_i && (state_q == ST_IDLE) && !rst_i;
   assign accept = gnt_b || gnt_r;

`ifdef MUNOC_RESP_PACKER_BURST_LOCK_EN
   logic lock_q, lock_d;

   // Lock engages on a granted non-last R beat and releases on its last beat
   always_comb begin
      lock_d = lock_q;
      if (gnt_r) lock_d = !rlast_i;
   end

   // Burst lock register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lock_q <= 1'b0;
      else       lock_q <= lock_d;
   end

   assign burst_lock = lock_q;
`else
   assign burst_lock = 1'b0;
`endif

   munoc_resp_rr_arbiter u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_b_i  (req_b),
      .req_r_i  (req_r),
      .lock_r_i (burst_lock),
      .update_i (accept && !burst_lock),
      .gnt_b_o  (gnt_b),
      .gnt_r_o  (gnt_r)
   );

   for (genvar k = 0; k < NBYTES; k++) begin : g_rev
      assign rdata_rev[8*byte_lane_rev(k, NBYTES) +: 8] = rdata_q[8*k +: 8];
   end

   // Response field capture on grant
   always_comb begin
      is_r_d  = is_r_q;
      dest_d  = dest_q;
      tid_d   = tid_q;
      resp_d  = resp_q;
      last_d  = last_q;
      rdata_d = rdata_q;
      if (gnt_r) begin
         is_r_d  = PKT_TYPE_R;
         dest_d  = rdest_i;
         tid_d   = rid_i;
         resp_d  = rresp_i;
         last_d  = rlast_i;
         rdata_d = rdata_i;
      end else if (gnt_b) begin
         is_r_d  = PKT_TYPE_B;
         dest_d  = bdest_i;
         tid_d   = bid_i;
         resp_d  = bresp_i;
         last_d  = 1'b0;
      end
   end

   // Response field registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         is_r_q  <= PKT_TYPE_B;
         dest_q  <= '0;
         tid_q   <= '0;
         resp_q  <= '0;
         last_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         is_r_q  <= is_r_d;
         dest_q  <= dest_d;
         tid_q   <= tid_d;
         resp_q  <= resp_d;
         last_q  <= last_d;
         rdata_q <= rdata_d;
      end
   end

   // Header and body flit formatting
   always_comb begin
      hdr_flit                           = '0;
      hdr_flit[TYPE_LSB]                 = is_r_q;
      hdr_flit[DEST_LSB +: BW_NODE_ID]   = dest_q;
      hdr_flit[TID_LSB +: BW_TID]        = tid_q;
      hdr_flit[RESP_LSB +: HDR_RESP_W]   = resp_q;
      hdr_flit[LAST_LSB]                 = last_q;
      body_flit = rdata_rev[(NB - 1 - int'(cnt_q)) * BW_FLIT +: BW_FLIT];
   end

   // FSM state and beat counter registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_HEAD;
         end
         ST_HEAD: begin
            if (flit_ready_i) begin
               if (is_r_q == PKT_TYPE_R) begin
                  state_d = ST_BODY;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_BODY: begin
            if (flit_ready_i) begin
               if (cnt_q == CW'(NB - 1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      bready_o     = 1'b0;
      rready_o     = 1'b0;
      flit_valid_o = 1'b0;
      flit_head_o  = 1'b0;
      flit_tail_o  = 1'b0;
      flit_data_o  = '0;
      case (state_q)
         ST_IDLE: begin
            bready_o = gnt_b;
            rready_o = gnt_r;
         end
         ST_HEAD: begin
            flit_valid_o = 1'b1;
            flit_head_o  = 1'b1;
            flit_tail_o  = (is_r_q == PKT_TYPE_B);
            flit_data_o  = hdr_flit;
         end
         ST_BODY: begin
            flit_valid_o = 1'b1;
            flit_tail_o  = (cnt_q == CW'(NB - 1));
            flit_data_o  = body_flit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_munoc_response_flit_packer.sv
// Directed bench for munoc_response_flit_packer (BW_FLIT=32, BW_RDATA=64).
module tb_munoc_response_flit_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bvalid = 1'b0, bready;
   logic [3:0]  bid = '0;
   logic [1:0]  bresp = '0;
   logic [3:0]  bdest = '0;
   logic        rvalid = 1'b0, rready;
   logic [3:0]  rid = '0;
   logic [63:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b0;
   logic [3:0]  rdest = '0;
   logic        flit_valid, flit_ready = 1'b1, flit_head, flit_tail;
   logic [31:0] flit_data;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        head;
      logic        tail;
      logic [31:0] data;
   } flit_t;

   flit_t fq[$];
   int    gq[$];   // grant order: 0 = B, 1 = R

   always #5 clk = ~clk;

   munoc_response_flit_packer #(
      .BW_FLIT(32), .BW_RDATA(64), .BW_TID(4), .BW_NODE_ID(4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bvalid_i     (bvalid),
      .bready_o     (bready),
      .bid_i        (bid),
      .bresp_i      (bresp),
      .bdest_i      (bdest),
      .rvalid_i     (rvalid),
      .rready_o     (rready),
      .rid_i        (rid),
      .rdata_i      (rdata),
      .rresp_i      (rresp),
      .rlast_i      (rlast),
      .rdest_i      (rdest),
      .flit_valid_o (flit_valid),
      .flit_ready_i (flit_ready),
      .flit_head_o  (flit_head),
      .flit_tail_o  (flit_tail),
      .flit_data_o  (flit_data)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (flit_valid && flit_ready) fq.push_back('{flit_head, flit_tail, flit_data});
         if (bready) gq.push_back(0);
         if (rready) gq.push_back(1);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bvalid = 1'b0;
      rvalid = 1'b0;
      flit_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      fq.delete();
      gq.delete();
   endtask

   task automatic drive_b(input logic [3:0] id, input logic [1:0] rs, input logic [3:0] d);
      bit got = 0;
      bid = id; bresp = rs; bdest = d; bvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bready) begin got = 1; break; end
      end
      @(posedge clk); #1 bvalid = 1'b0;
      n_chk++;
      if (!got) $display("FAIL b_handshake: bready seen=%0d required=1", got);
      else n_pass++;
   endtask

   task automatic drive_r(input logic [3:0] id, input logic [63:0] dat, input logic [1:0] rs,
                          input logic lst, input logic [3:0] d);
      bit got = 0;
      rid = id; rdata = dat; rresp = rs; rlast = lst; rdest = d; rvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rready) begin got = 1; break; end
      end
      @(posedge clk); #1 rvalid = 1'b0;
      n_chk++;
      if (!got) $display("FAIL r_handshake: rready seen=%0d required=1", got);
      else n_pass++;
   endtask

   task automatic wait_flits(input int n, input string name);
      int k = 0;
      while (fq.size() < n && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      repeat (4) @(posedge clk);
      #1;
      n_chk++;
      if (fq.size() != n) $display("FAIL %s_flit_count: got %0d required %0d", name, fq.size(), n);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; bvalid = 1'b1; rvalid = 1'b1; flit_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (flit_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", flit_valid); else n_pass++;
      n_chk++; if (flit_head !== 1'b0) $display("FAIL rst_head: got %b required 0", flit_head); else n_pass++;
      n_chk++; if (flit_tail !== 1'b0) $display("FAIL rst_tail: got %b required 0", flit_tail); else n_pass++;
      n_chk++; if (flit_data !== 32'h0) $display("FAIL rst_data: got %h required 0", flit_data); else n_pass++;
      n_chk++; if (bready !== 1'b0) $display("FAIL rst_bready: got %b required 0", bready); else n_pass++;
      n_chk++; if (rready !== 1'b0) $display("FAIL rst_rready: got %b required 0", rready); else n_pass++;
      bvalid = 1'b0; rvalid = 1'b0;
   endtask

   task automatic test_single_b();
      do_reset();
      bid = 4'h3; bresp = 2'd2; bdest = 4'd5; bvalid = 1'b1;
      @(negedge clk);
      n_chk++; if (bready !== 1'b1) $display("FAIL b_bready_pulse: got %b required 1", bready); else n_pass++;
      n_chk++; if (flit_valid !== 1'b0) $display("FAIL b_idle_valid: got %b required 0", flit_valid); else n_pass++;
      @(posedge clk); #1 bvalid = 1'b0;
      @(negedge clk);
      n_chk++; if (bready !== 1'b0) $display("FAIL b_bready_drop: got %b required 0", bready); else n_pass++;
      n_chk++; if (flit_valid !== 1'b1) $display("FAIL b_valid: got %b required 1", flit_valid); else n_pass++;
      n_chk++; if ({flit_head, flit_tail} !== 2'b11) $display("FAIL b_head_tail: got %b required 11", {flit_head, flit_tail}); else n_pass++;
      n_chk++; if (flit_data !== 32'h29C0_0000) $display("FAIL b_header: got %h required 29c00000", flit_data); else n_pass++;
      n_chk++; if (flit_data[31] !== 1'b0) $display("FAIL b_type: got %b required 0", flit_data[31]); else n_pass++;
      n_chk++; if (flit_data[30:27] !== 4'd5) $display("FAIL b_dest: got %0d required 5", flit_data[30:27]); else n_pass++;
      n_chk++; if (flit_data[26:23] !== 4'd3) $display("FAIL b_tid: got %0d required 3", flit_data[26:23]); else n_pass++;
      n_chk++; if (flit_data[22:21] !== 2'd2) $display("FAIL b_resp: got %0d required 2", flit_data[22:21]); else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if (flit_valid !== 1'b0) $display("FAIL b_after_tail: got %b required 0", flit_valid); else n_pass++;
      n_chk++; if (gq.size() != 1) $display("FAIL b_grant_count: got %0d required 1", gq.size()); else n_pass++;
      n_chk++; if (fq.size() != 1) $display("FAIL b_flit_count: got %0d required 1", fq.size()); else n_pass++;
   endtask

   task automatic test_single_r();
      logic [31:0] exp_d [3] = '{32'h9530_0000, 32'h7766_5544, 32'h3322_1100};
      logic [1:0]  exp_ht[3] = '{2'b10, 2'b00, 2'b01};
      do_reset();
      drive_r(4'hA, 64'h0011_2233_4455_6677, 2'd1, 1'b1, 4'd2);
      wait_flits(3, "r");
      for (int i = 0; i < 3 && i < fq.size(); i++) begin
         n_chk++;
         if (fq[i].data !== exp_d[i]) $display("FAIL r_flit%0d_data: got %h required %h", i, fq[i].data, exp_d[i]);
         else n_pass++;
         n_chk++;
         if ({fq[i].head, fq[i].tail} !== exp_ht[i])
            $display("FAIL r_flit%0d_head_tail: got %b required %b", i, {fq[i].head, fq[i].tail}, exp_ht[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int k = 0;
      int exp_g[4] = '{0, 1, 0, 1};
      do_reset();
      bid = 4'h1; bresp = 2'd0; bdest = 4'd3;
      rid = 4'h2; rdata = 64'h0102_0304_0506_0708; rresp = 2'd0; rlast = 1'b1; rdest = 4'd4;
      bvalid = 1'b1; rvalid = 1'b1;
      while (gq.size() < 4 && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      @(posedge clk); #1 bvalid = 1'b0; rvalid = 1'b0;
      wait_flits(8, "b2b");
      n_chk++; if (gq.size() != 4) $display("FAIL b2b_grants: got %0d required 4", gq.size()); else n_pass++;
      for (int i = 0; i < 4 && i < gq.size(); i++) begin
         n_chk++;
         if (gq[i] != exp_g[i]) $display("FAIL b2b_order%0d: got %0d required %0d", i, gq[i], exp_g[i]);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive_r(4'h6, 64'h8899_AABB_CCDD_EEFF, 2'd0, 1'b1, 4'd1);
      @(posedge clk); #1;
      @(posedge clk); #1 flit_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++; if (flit_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b required 1", i, flit_valid); else n_pass++;
         n_chk++; if (flit_data !== 32'hBBAA_9988) $display("FAIL stall_data%0d: got %h required bbaa9988", i, flit_data); else n_pass++;
         n_chk++; if (flit_tail !== 1'b1) $display("FAIL stall_tail%0d: got %b required 1", i, flit_tail); else n_pass++;
      end
      @(posedge clk); #1 flit_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (flit_data !== 32'hBBAA_9988) $display("FAIL stall_release_data: got %h required bbaa9988", flit_data); else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if (flit_valid !== 1'b0) $display("FAIL stall_done: got %b required 0", flit_valid); else n_pass++;
      n_chk++; if (fq.size() != 3) $display("FAIL stall_flit_count: got %0d required 3", fq.size()); else n_pass++;
      if (fq.size() == 3) begin
         n_chk++; if (fq[1].data !== 32'hFFEE_DDCC) $display("FAIL stall_body0: got %h required ffeeddcc", fq[1].data); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_r(4'h9, 64'h1111_2222_3333_4444, 2'd0, 1'b1, 4'd6);
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      n_chk++; if (flit_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", flit_valid); else n_pass++;
      n_chk++; if (flit_head !== 1'b0) $display("FAIL midrst_head: got %b required 0", flit_head); else n_pass++;
      n_chk++; if (flit_tail !== 1'b0) $display("FAIL midrst_tail: got %b required 0", flit_tail); else n_pass++;
      n_chk++; if (flit_data !== 32'h0) $display("FAIL midrst_data: got %h required 0", flit_data); else n_pass++;
      @(posedge clk); #1 rst = 1'b0;
      fq.delete();
      gq.delete();
      drive_r(4'h5, 64'h0011_2233_4455_6677, 2'd3, 1'b0, 4'd7);
      wait_flits(3, "midrst");
      if (fq.size() == 3) begin
         n_chk++; if (fq[0].head !== 1'b1) $display("FAIL midrst_head_first: got %b required 1", fq[0].head); else n_pass++;
         n_chk++; if (fq[0].data !== 32'hBAE0_0000) $display("FAIL midrst_header: got %h required bae00000", fq[0].data); else n_pass++;
         n_chk++; if (fq[2].data !== 32'h3322_1100) $display("FAIL midrst_last_body: got %h required 33221100", fq[2].data); else n_pass++;
      end
   endtask

   task automatic test_burst_lock();
`ifdef MUNOC_RESP_PACKER_BURST_LOCK_EN
      int exp_g[5] = '{1, 1, 1, 1, 0};
`else
      int exp_g[5] = '{1, 0, 1, 1, 1};
`endif
      do_reset();
      fork
         begin
            drive_r(4'h7, 64'hA0A1_A2A3_A4A5_A6A7, 2'd0, 1'b0, 4'd2);
            drive_r(4'h7, 64'hB0B1_B2B3_B4B5_B6B7, 2'd0, 1'b0, 4'd2);
            drive_r(4'h7, 64'hC0C1_C2C3_C4C5_C6C7, 2'd0, 1'b0, 4'd2);
            drive_r(4'h7, 64'hD0D1_D2D3_D4D5_D6D7, 2'd0, 1'b1, 4'd2);
         end
         begin
            @(posedge clk); #1;
            drive_b(4'hC, 2'd1, 4'd9);
         end
      join
      wait_flits(13, "burst");
      n_chk++; if (gq.size() != 5) $display("FAIL burst_grants: got %0d required 5", gq.size()); else n_pass++;
      for (int i = 0; i < 5 && i < gq.size(); i++) begin
         n_chk++;
         if (gq[i] != exp_g[i]) $display("FAIL burst_order%0d: got %0d required %0d", i, gq[i], exp_g[i]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single_b();
      test_single_r();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_burst_lock();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/munoc_response_flit_packer.md
Name: munoc_response_flit_packer

Overview:
- Slave-side response packetizer.
- Accepts AXI B and R channel responses from a slave, arbitrates between them, and serializes each response into header plus body flits on a BNI response link.
- Sits directly upstream of the master-side response receiver, which decodes these packets back into BRESP/RRESP/RDATA.
- Performs the RDATA byte-lane reversal that the receiver undoes.

Parameters:
- BW_FLIT, 32, flit payload width in bits.
- BW_RDATA, 64, AXI RDATA width; must be a multiple of BW_FLIT and of 8.
- BW_TID, 4, AXI transaction ID width.
- BW_NODE_ID, 4, destination master node ID width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- bvalid  input  1  B response valid.
- bready  output  1  B response accepted.
- bid  input  BW_TID  B transaction ID.
- bresp  input  2  B response code.
- bdest  input  BW_NODE_ID  master node ID for the B response.
- rvalid  input  1  R beat valid.
- rready  output  1  R beat accepted.
- rid  input  BW_TID  R transaction ID.
- rdata  input  BW_RDATA  read data.
- rresp  input  2  R response code.
- rlast  input  1  last beat of the R burst.
- rdest  input  BW_NODE_ID  master node ID for the R response.
- flit_valid  output  1  link flit valid.
- flit_ready  input  1  link backpressure.
- flit_head  output  1  flit is a header.
- flit_tail  output  1  flit is the last of its packet.
- flit_data  output  BW_FLIT  flit payload.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous, active-high. All state clears immediately on `rst` assertion, including mid-packet; the partial packet is dropped.
- Reset values: flit_valid=0, flit_head=0, flit_tail=0, flit_data=0, bready=0, rready=0, FSM=IDLE, beat counter=0, round-robin pointer=B.
- Header payload layout, MSB first: type (1 = R, 0 = B), dest, tid, resp, rlast. rlast=0 for B packets. Remaining LSBs are zero-padded.
- Elaboration-time check: the header must fit, i.e. 1+BW_NODE_ID+BW_TID+2+1 <= BW_FLIT.
- Body: NB = BW_RDATA/BW_FLIT flits.
  - The latched RDATA is byte-reversed: byte k moves to byte (BW_RDATA/8-1-k).
  - The reversed word is sent most-significant flit first.
- B packet: one flit, head=1, tail=1.
- R packet: 1+NB flits. Header has head=1, tail=0; the final body flit has tail=1.
- FSM states:
  - IDLE: if any of bvalid/rvalid is high, select one. Both high: round-robin, and the pointer flips to the non-granted channel after each grant. Pulse the matching bready or rready for one cycle; response fields are latched into registers that cycle; go to HEAD.
  - HEAD: flit_valid=1 with the header. On flit_ready: B → IDLE; R → BODY with counter=0.
  - BODY: flit_valid=1 with body flit [counter]. On flit_ready, counter increments; on counter==NB-1 → IDLE.
- Handshakes:
  - bready/rready are asserted only in IDLE, and only for the granted channel. Latency from input valid to first flit_valid is 1 cycle.
  - flit_valid stays high and flit_data stays stable until flit_ready. Data must not change while stalled.
  - A new response is accepted only after the tail flit transfers. There is no overlap: one packet is in flight at a time.
  - Throughput: one B per 2 cycles, one R beat per NB+2 cycles when the link is unstalled.
- Boundary cases:
  - NB=1: BODY lasts exactly one flit.
  - flit_ready held low indefinitely: the block holds its state, with no timeout.
  - bvalid and rvalid rising in the same cycle as a tail transfer are not accepted until the next IDLE cycle.

Optional Feature:
- Macro: MUNOC_RESP_PACKER_BURST_LOCK_EN.
- Defined: after an R beat with rlast=0 is granted, arbitration is locked to R until a beat with rlast=1 is sent. bvalid waits during the lock. The round-robin pointer is not updated during the lock.
- Undefined: every packet is arbitrated independently by round-robin, so B packets may interleave between R beats of one burst.

Decomposition:
- Shared package munoc_resp_packet_pkg holds:
  - packet type constants (PKT_TYPE_B=0, PKT_TYPE_R=1);
  - header field widths and offsets, and the header-width function;
  - FSM state encoding (IDLE, HEAD, BODY);
  - the byte-lane reversal function, shared with the receiver side.
- One natural sub-module: munoc_resp_rr_arbiter, a 2-input round-robin grant with a lock input.

Test Plan:
- Single B, BW_TID=4, bid=0x3, bresp=2, bdest=5, flit_ready=1: one flit with head=1 and tail=1; header fields read type=0, dest=5, tid=3, resp=2; bready pulses for one cycle.
- Single R, rdata=0x0011223344556677, rid=0xA, rlast=1, BW_FLIT=32: header, then body 0x77665544, then 0x33221100 with tail=1 on the last.
- Simultaneous bvalid and rvalid held high for 4 packets: grant order B, R, B, R.
- flit_ready=0 for 5 cycles in BODY after the first body flit: flit_data and flit_valid stable; the counter advances only after ready returns.
- rst asserted mid-BODY: all outputs 0 in the same cycle; after release, the next R is sent from its header.
- With MUNOC_RESP_PACKER_BURST_LOCK_EN, a 4-beat R burst plus a pending B: all 4 R packets are sent before B. Without the macro: B is sent after the first R beat.
